// File: rtl/sequenciador_banco_pkg.sv
// Shared definitions for the register-file sequencer: opcodes and FSM state encoding.
// Imported by the ALU, the controller and the bench so decode stays in one place.
package sequenciador_banco_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLL  = 3'd6;
    localparam logic [2:0] OP_MOVI = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/sequenciador_banco_ula.sv
// ula_16: combinational ALU for the sequencer; all results wrap modulo 2^DATA_W.
// Shift amount uses only the low four bits of b.
module ula_16
    import sequenciador_banco_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  y = a << b[3:0];
            OP_MOVI: y = imm;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/sequenciador_banco.sv
// Four-state controller driving the register-file ports: accept, read, execute, write back.
// State | meaning
//   IDLE  | waiting for a command handshake; cmd_ready high
//   READ  | read addresses stable, operands captured on the closing edge
//   EXEC  | ALU result registered onto result/write port on the closing edge
//   WRITE | RegWrite and done high for this single cycle
module sequenciador_banco
    import sequenciador_banco_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] Read1,
    output logic [ADDR_W-1:0] Read2,
    input  logic [DATA_W-1:0] Data1,
    input  logic [DATA_W-1:0] Data2,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zero;
    logic              write_en;

    assign cmd_ready = (state == IDLE) && !reset;
    assign write_en  = !(ZERO_REG_RO && (rd_q == '0));

    ula_16 #(.DATA_W(DATA_W)) u_ula (
        .op   (op_q),
        .a    (op_a),
        .b    (op_b),
        .imm  (imm_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            Read1     <= '0;
            Read2     <= '0;
            WriteReg  <= '0;
            WriteData <= '0;
            RegWrite  <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        imm_q <= cmd_imm;
                        Read1 <= cmd_rs;
                        Read2 <= cmd_rt;
                        state <= READ;
                    end
                end
                READ: begin
                    op_a  <= Data1;
                    op_b  <= Data2;
                    state <= EXEC;
                end
                EXEC: begin
                    // A suppressed write still retires: done and result update regardless.
                    result    <= alu_y;
                    zero      <= alu_zero;
                    WriteReg  <= rd_q;
                    WriteData <= alu_y;
                    RegWrite  <= write_en;
                    done      <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    RegWrite <= 1'b0;
                    done     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_banco.sv
// Directed bench for sequenciador_banco with behavioural 8x16 register files.
// A second instance with ZERO_REG_RO=1 covers write suppression to r0.
module tb_sequenciador_banco;
    import sequenciador_banco_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid_z = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [2:0]  cmd_rd = 3'd0;
    logic [2:0]  cmd_rs = 3'd0;
    logic [2:0]  cmd_rt = 3'd0;
    logic [15:0] cmd_imm = 16'h0;

    logic        cmd_ready, RegWrite, done, zero;
    logic [2:0]  Read1, Read2, WriteReg;
    logic [15:0] Data1, Data2, WriteData, result;

    logic        cmd_ready_z, RegWrite_z, done_z, zero_z;
    logic [2:0]  Read1_z, Read2_z, WriteReg_z;
    logic [15:0] Data1_z, Data2_z, WriteData_z, result_z;

    logic [15:0] rf   [8];
    logic [15:0] rf_z [8];

    int tests = 0;
    int failed = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) begin
                rf[i]   <= 16'h0;
                rf_z[i] <= 16'h0;
            end
            rf[1]   <= 16'h0005;
            rf[2]   <= 16'h0003;
            rf_z[1] <= 16'h0005;
            rf_z[2] <= 16'h0003;
        end else begin
            if (RegWrite)   rf[WriteReg]     <= WriteData;
            if (RegWrite_z) rf_z[WriteReg_z] <= WriteData_z;
        end
    end

    assign Data1   = rf[Read1];
    assign Data2   = rf[Read2];
    assign Data1_z = rf_z[Read1_z];
    assign Data2_z = rf_z[Read2_z];

    sequenciador_banco #(.DATA_W(16), .ADDR_W(3), .ZERO_REG_RO(1'b0)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
        .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .done(done), .result(result), .zero(zero)
    );

    sequenciador_banco #(.DATA_W(16), .ADDR_W(3), .ZERO_REG_RO(1'b1)) dut_z (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid_z), .cmd_ready(cmd_ready_z),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
        .Read1(Read1_z), .Read2(Read2_z), .Data1(Data1_z), .Data2(Data2_z),
        .WriteReg(WriteReg_z), .WriteData(WriteData_z), .RegWrite(RegWrite_z),
        .done(done_z), .result(result_z), .zero(zero_z)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, then scramble cmd_* to confirm fields were latched at acceptance.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt,
                           input logic [15:0] imm, input logic [15:0] exp);
        int n;
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_rd = ~rd; cmd_rs = ~rs; cmd_rt = ~rt; cmd_imm = ~imm;
        check({tag, "_read1"}, Read1, rs);
        check({tag, "_read2"}, Read2, rt);
        check({tag, "_busy"}, cmd_ready, 0);
        tick();
        check({tag, "_exec_done"}, done, 0);
        tick();
        check({tag, "_regwrite"}, RegWrite, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_writereg"}, WriteReg, rd);
        check({tag, "_writedata"}, WriteData, exp);
        check({tag, "_result"}, result, exp);
        check({tag, "_zero"}, zero, (exp == 16'h0));
        tick();
        check({tag, "_regwrite_off"}, RegWrite, 0);
        check({tag, "_done_off"}, done, 0);
        check({tag, "_rf"}, rf[rd], exp);
        check({tag, "_ready_again"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        preload = 1'b0;
        check("rst_ready", cmd_ready, 0);
        check("rst_read1", Read1, 0);
        check("rst_read2", Read2, 0);
        check("rst_writereg", WriteReg, 0);
        check("rst_writedata", WriteData, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_release", cmd_ready, 1);

        run_cmd("add_r3",  OP_ADD,  3'd3, 3'd1, 3'd2, 16'h0000, 16'h0008);
        run_cmd("movi_r4", OP_MOVI, 3'd4, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF);
        run_cmd("add_ovf", OP_ADD,  3'd5, 3'd4, 3'd1, 16'h0000, 16'h0004);
        run_cmd("sub_neg", OP_SUB,  3'd6, 3'd2, 3'd1, 16'h0000, 16'hFFFE);
        run_cmd("slt",     OP_SLT,  3'd7, 3'd6, 3'd1, 16'h0000, 16'h0001);
        run_cmd("sll",     OP_SLL,  3'd4, 3'd4, 3'd2, 16'h0000, 16'hFFF8);
        run_cmd("and",     OP_AND,  3'd5, 3'd1, 3'd2, 16'h0000, 16'h0001);
        run_cmd("or",      OP_OR,   3'd6, 3'd1, 3'd2, 16'h0000, 16'h0007);
        run_cmd("xor",     OP_XOR,  3'd7, 3'd1, 3'd2, 16'h0000, 16'h0006);
        run_cmd("sub_zero",OP_SUB,  3'd5, 3'd1, 3'd1, 16'h0000, 16'h0000);

        // Back-to-back with cmd_valid held: second command must see the first's write.
        cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs = 3'd1; cmd_rt = 3'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_rs = 3'd3; cmd_rt = 3'd3;
        check("b2b_busy1", cmd_ready, 0);
        tick();
        check("b2b_busy2", cmd_ready, 0);
        tick();
        check("b2b_busy3", cmd_ready, 0);
        check("b2b_wd1", WriteData, 16'h0008);
        tick();
        check("b2b_ready", cmd_ready, 1);
        check("b2b_rf1", rf[3], 16'h0008);
        tick();
        cmd_valid = 1'b0;
        check("b2b_read1", Read1, 3);
        check("b2b_read2", Read2, 3);
        tick();
        tick();
        check("b2b_wd2", WriteData, 16'h0010);
        tick();
        check("b2b_rf2", rf[3], 16'h0010);

        // Same ADD rd=0 into both instances: only the writable one updates r0.
        cmd_op = OP_ADD; cmd_rd = 3'd0; cmd_rs = 3'd1; cmd_rt = 3'd2;
        cmd_valid = 1'b1; cmd_valid_z = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_valid_z = 1'b0;
        tick();
        tick();
        check("r0_we_open", RegWrite, 1);
        check("r0_we_ro", RegWrite_z, 0);
        check("r0_done_ro", done_z, 1);
        check("r0_result_ro", result_z, 16'h0008);
        check("r0_zero_ro", zero_z, 0);
        tick();
        check("r0_rf_open", rf[0], 16'h0008);
        check("r0_rf_ro", rf_z[0], 16'h0000);
        check("r0_done_ro_off", done_z, 0);
        check("r0_ready_ro", cmd_ready_z, 1);

        // Reset during EXEC discards the in-flight command.
        cmd_op = OP_ADD; cmd_rd = 3'd3; cmd_rs = 3'd1; cmd_rt = 3'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rx_regwrite", RegWrite, 0);
        check("rx_done", done, 0);
        check("rx_result", result, 0);
        check("rx_read1", Read1, 0);
        check("rx_ready_low", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("rx_ready", cmd_ready, 1);
        tick();
        check("rx_regwrite2", RegWrite, 0);
        tick();
        check("rx_rf3", rf[3], 16'h0010);
        check("rx_result2", result, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
